// File: rtl/locked_prio_irq_ctrl.sv
// locked_prio_irq_ctrl
//
// Key-locked priority interrupt controller. A serial key is shifted into
// key_reg. Each request bit is XORed with key_reg and KEY_POL, so the requests
// pass through unchanged only when the correct key has been loaded. In the RUN
// state a two-register pipeline turns the effective requests into one grant:
//   stage 1 : registers the effective requests and the channel enables
//   stage 2 : picks the lowest bus, then the lowest enabled channel, and loads
//             the result into the grant output register
// A grant stays on the outputs until the consumer acknowledges it.
//
// Ports
//   clk         single clock; all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   en          per-channel enable (NCH bits), shared by all buses
//   req         request vector; bit b*NCH+c is bus b, channel c
//   key_in      serial key data, shifted in MSB first
//   key_shift   shift strobe; leaves RUN and enters LOAD
//   key_done    key commit strobe (LOAD -> RUN)
//   grant_ack   consumer accepts the grant on the current outputs
//   grant_valid a grant is on the outputs
//   grant_bus   bus index of the grant
//   grant_ch    channel index of the grant
//   run         the controller is in RUN
module locked_prio_irq_ctrl #(
  parameter int NCH  = 9,
  parameter int NBUS = 3,
  parameter logic [NBUS*NCH-1:0] KEY_POL = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NCH-1:0]                         en,
  input  logic [NBUS*NCH-1:0]                    req,
  input  logic                                   key_in,
  input  logic                                   key_shift,
  input  logic                                   key_done,
  input  logic                                   grant_ack,
  output logic                                   grant_valid,
  output logic [(NBUS > 1 ? $clog2(NBUS) : 1)-1:0] grant_bus,
  output logic [$clog2(NCH)-1:0]                 grant_ch,
  output logic                                   run
);

  localparam int KEYW = NBUS * NCH;
  localparam int BW   = (NBUS > 1) ? $clog2(NBUS) : 1;
  localparam int CW   = $clog2(NCH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [KEYW-1:0]  key_reg;
  logic [KEYW-1:0]  s1_eff_reg;
  logic [NCH-1:0]   s1_en_reg;

  logic [KEYW-1:0]  eff;
  logic [KEYW-1:0]  cand;
  logic             win_found;
  logic [BW-1:0]    win_bus;
  logic [CW-1:0]    win_ch;

  // Effective request: equals req only when key_reg matches KEY_POL.
  assign eff = req ^ key_reg ^ KEY_POL;

  // A stage-1 bit is a candidate only if its channel is enabled.
  genvar gi;
  generate
    for (gi = 0; gi < KEYW; gi++) begin : g_cand
      assign cand[gi] = s1_eff_reg[gi] & s1_en_reg[gi % NCH];
    end
  endgenerate

  // Priority select. Scanning from the highest index down lets the
  // lowest bus / lowest channel overwrite any earlier match.
  always_comb begin
    win_found = 1'b0;
    win_bus   = '0;
    win_ch    = '0;
    for (int b = NBUS - 1; b >= 0; b--) begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (cand[b*NCH + c]) begin
          win_found = 1'b1;
          win_bus   = BW'(b);
          win_ch    = CW'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      key_reg     <= '0;
      s1_eff_reg  <= '0;
      s1_en_reg   <= '0;
      grant_valid <= 1'b0;
      grant_bus   <= '0;
      grant_ch    <= '0;
      run         <= 1'b0;
    end else begin
      // The shift has precedence over key_done in every state.
      if (key_shift) begin
        key_reg <= {key_reg[KEYW-2:0], key_in};
      end

      case (state_reg)
        IDLE: begin
          run <= 1'b0;
          if (key_shift) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (key_done && !key_shift) begin
            state_reg <= RUN;
            run       <= 1'b1;
          end else begin
            run <= 1'b0;
          end
        end
        RUN: begin
          if (key_shift) begin
            state_reg <= LOAD;
            run       <= 1'b0;
          end else begin
            run <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          run       <= 1'b0;
        end
      endcase

      // Pipeline runs only while staying in RUN; leaving RUN flushes it and
      // any pending grant, regardless of grant_ack on that edge.
      if (state_reg == RUN && !key_shift) begin
        s1_eff_reg <= eff;
        s1_en_reg  <= en;
        if (!grant_valid || grant_ack) begin
          grant_valid <= win_found;
          grant_bus   <= win_bus;
          grant_ch    <= win_ch;
        end
      end else begin
        s1_eff_reg  <= '0;
        s1_en_reg   <= '0;
        grant_valid <= 1'b0;
        grant_bus   <= '0;
        grant_ch    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_locked_prio_irq_ctrl.sv
// Testbench for locked_prio_irq_ctrl (default parameters).
// A behavioural model tracks the mode (idle/load/run), the key, a one-cycle
// snapshot of the enabled effective requests and the presented grant. The
// winner is the lowest set flat index i, giving bus i/NCH and channel i%NCH.
module tb_locked_prio_irq_ctrl;

  localparam int NCH  = 9;
  localparam int NBUS = 3;
  localparam int KEYW = NBUS * NCH;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  en = '0;
  logic [KEYW-1:0] req = '0;
  logic            key_in = 1'b0;
  logic            key_shift = 1'b0;
  logic            key_done = 1'b0;
  logic            grant_ack = 1'b0;
  logic            grant_valid;
  logic [1:0]      grant_bus;
  logic [3:0]      grant_ch;
  logic            run;

  always #5 clk = ~clk;

  locked_prio_irq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .key_in      (key_in),
    .key_shift   (key_shift),
    .key_done    (key_done),
    .grant_ack   (grant_ack),
    .grant_valid (grant_valid),
    .grant_bus   (grant_bus),
    .grant_ch    (grant_ch),
    .run         (run)
  );

  // Reference model state
  int              m_state = M_IDLE;
  logic [KEYW-1:0] m_key = '0;
  logic [KEYW-1:0] m_snap = '0;
  logic            m_v = 1'b0;
  int              m_bus = 0;
  int              m_ch = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [KEYW-1:0] v);
    for (int i = 0; i < KEYW; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [KEYW-1:0] masked;
    int w;
    if (rst) begin
      m_state = M_IDLE;
      m_key   = '0;
      m_snap  = '0;
      m_v     = 1'b0;
      m_bus   = 0;
      m_ch    = 0;
    end else begin
      masked = (req ^ m_key) & {NBUS{en}};
      if (m_state == M_RUN && !key_shift) begin
        if (!m_v || grant_ack) begin
          w   = lowest_set(m_snap);
          m_v = (w >= 0);
          if (w >= 0) begin
            m_bus = w / NCH;
            m_ch  = w % NCH;
          end
        end
        m_snap = masked;
      end else begin
        m_snap = '0;
        m_v    = 1'b0;
      end
      case (m_state)
        M_IDLE: if (key_shift) m_state = M_LOAD;
        M_LOAD: if (key_done && !key_shift) m_state = M_RUN;
        default: if (key_shift) m_state = M_LOAD;
      endcase
      if (key_shift) m_key = {m_key[KEYW-2:0], key_in};
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("run", run, (m_state == M_RUN));
    chk("grant_valid", grant_valid, m_v);
    if (m_v) begin
      chk("grant_bus", grant_bus, m_bus);
      chk("grant_ch", grant_ch, m_ch);
    end
  endtask

  task automatic load_key(input logic [KEYW-1:0] k);
    for (int i = KEYW - 1; i >= 0; i--) begin
      key_in    = k[i];
      key_shift = 1'b1;
      tick();
    end
    key_shift = 1'b0;
    key_in    = 1'b0;
    key_done  = 1'b1;
    tick();
    key_done  = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    tick();
    tick();
    chk("rst_valid", grant_valid, 0);
    chk("rst_bus", grant_bus, 0);
    chk("rst_ch", grant_ch, 0);
    chk("rst_run", run, 0);
    rst = 1'b0;
    tick();
    chk("idle_run", run, 0);

    // Correct key, single request bus1/ch4, two-edge latency
    load_key('0);
    chk("key_ok_run", run, 1);
    en  = 9'h1FF;
    req = '0;
    req[13] = 1'b1;
    tick();
    chk("lat1_valid", grant_valid, 0);
    tick();
    chk("lat2_valid", grant_valid, 1);
    chk("lat2_bus", grant_bus, 1);
    chk("lat2_ch", grant_ch, 4);
    req = '0;
    tick();
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    chk("drain_valid", grant_valid, 0);

    // Priority order across buses, held while no ack
    req[2] = 1'b1; req[10] = 1'b1; req[20] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_bus", grant_bus, 0);
      chk("hold_ch", grant_ch, 2);
    end
    req[2] = 1'b0;
    tick();
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    chk("prio2_bus", grant_bus, 1);
    chk("prio2_ch", grant_ch, 1);
    req[10] = 1'b0;
    tick();
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    chk("prio3_bus", grant_bus, 2);
    chk("prio3_ch", grant_ch, 2);
    req[20] = 1'b0;
    tick();
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    chk("prio_end_valid", grant_valid, 0);

    // Enable mask blocks the only request
    en  = 9'h0FE;
    req = '0;
    req[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mask_valid", grant_valid, 0);
    end

    // Wrong key: key bit 0 set yields a spurious bus0/ch0 grant
    req = '0;
    en  = 9'h1FF;
    load_key(27'h1);
    tick();
    tick();
    chk("wrongkey_valid", grant_valid, 1);
    chk("wrongkey_bus", grant_bus, 0);
    chk("wrongkey_ch", grant_ch, 0);

    // Leaving RUN with a pending grant and ack on the same edge
    key_shift = 1'b1;
    grant_ack = 1'b1;
    tick();
    key_shift = 1'b0;
    grant_ack = 1'b0;
    chk("leave_valid", grant_valid, 0);
    chk("leave_run", run, 0);
    key_shift = 1'b1;
    key_done  = 1'b1;
    tick();
    key_shift = 1'b0;
    key_done  = 1'b0;
    chk("shift_done_run", run, 0);

    // Random traffic under the correct key
    load_key('0);
    for (int i = 0; i < 200; i++) begin
      req       = KEYW'($urandom & $urandom & $urandom);
      en        = NCH'($urandom);
      grant_ack = 1'($urandom_range(0, 1));
      tick();
    end
    grant_ack = 1'b0;

    // Random traffic under a random key
    load_key(KEYW'($urandom));
    for (int i = 0; i < 200; i++) begin
      req       = KEYW'($urandom);
      en        = NCH'($urandom);
      grant_ack = 1'($urandom_range(0, 1));
      tick();
    end
    grant_ack = 1'b0;

    // Asynchronous reset between edges with a grant pending
    req = '0;
    load_key('0);
    en  = 9'h1FF;
    req[5] = 1'b1;
    tick();
    tick();
    chk("pre_rst_valid", grant_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_valid", grant_valid, 0);
    chk("async_bus", grant_bus, 0);
    chk("async_ch", grant_ch, 0);
    chk("async_run", run, 0);
    tick();
    rst = 1'b0;
    req = '0;
    tick();
    chk("post_rst_run", run, 0);
    load_key('0);
    tick();
    tick();
    chk("post_rst_empty", grant_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
